fifo_terminal: RTL and testbench
================================

Name: fifo_terminal

Overview:
- Device-side endpoint for one controller position of the shared FIFO bus.
- The bus core pops packets from terminals and pushes packets to them; this block is the terminal the bus talks to.
- TX path: agent writes packets into a show-ahead queue, which the bus drains with pndng/D_pop/pop.
- RX path: accepts bus push/D_push, filters by destination ID, and queues accepted packets for the agent/monitor.
- The test environment instantiates one per [bit][controller] slot of the bus interface arrays.

Parameters:
- tama_de_paquete, 32, packet width in bits; must be >= 16.
- profundidad, 8, entries per queue; power of 2, >= 2.
- ID, 0, this terminal's 8-bit destination address.
- BROADCAST, 8'hFF, destination address accepted by every terminal.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  agent writes wr_data into TX queue.
- wr_data  input  tama_de_paquete  packet to transmit; bits [tama_de_paquete-1 -: 8] = destination ID.
- pndng  output  1  TX queue non-empty (to bus).
- D_pop  output  tama_de_paquete  TX head packet (to bus).
- pop  input  1  bus consumes the TX head.
- push  input  1  bus delivers D_push to this terminal.
- D_push  input  tama_de_paquete  packet from bus.
- rx_valid  output  1  RX queue non-empty.
- rx_data  output  tama_de_paquete  RX head packet.
- rd_en  input  1  agent consumes the RX head.
- tx_count  output  $clog2(profundidad+1)  TX occupancy.
- rx_count  output  $clog2(profundidad+1)  RX occupancy.
- tx_full  output  1  tx_count == profundidad.
- tx_overflow  output  1  sticky: agent write dropped because TX queue was full.
- pop_underflow  output  1  sticky: pop received while TX queue was empty.
- rx_overflow  output  1  sticky: accepted push dropped because RX queue was full.
- rx_drop_cnt  output  16  count of pushes discarded by the ID filter; saturates at 16'hFFFF.

Behaviour:
- Reset: one clk with reset=1 clears all pointers, counts, sticky flags and rx_drop_cnt. Every output is 0 from the following cycle.
- Reset mid-operation discards all queued packets. wr_en, pop, push and rd_en are ignored during the reset cycle.
- Both queues are circular buffers with read/write pointers (wrap modulo profundidad) and separate occupancy counters. There is no pointer-compare ambiguity.
- Show-ahead reads:
  - pndng = (tx_count != 0). D_pop = TX head when pndng, else 0.
  - rx_valid = (rx_count != 0). rx_data = RX head when rx_valid, else 0.
  - All four are combinational from registered state, with no input-to-output paths.
- TX write: wr_en with !tx_full stores the packet at the tail. The packet is visible on D_pop/pndng the next cycle if the queue was empty (1-cycle latency).
- TX pop: pop with pndng advances the head. The next head, or pndng=0, appears the following cycle.
- Simultaneous TX write and pop:
  - Queue full: both happen; count unchanged.
  - Queue empty: write accepted; pop flagged as pop_underflow (write data is not yet visible).
- TX overflow: wr_en when full and no pop in the same cycle. Write dropped, tx_overflow set.
- Pop when empty: no state change except pop_underflow set.
- RX filter: a push is accepted iff D_push[tama_de_paquete-1 -: 8] == ID or == BROADCAST.
  - Rejected pushes increment rx_drop_cnt (saturating) and are otherwise ignored.
- RX write: accepted push with rx_count < profundidad is stored at the tail. rx_valid rises the next cycle.
  - Accepted push with queue full and no rd_en: packet dropped, rx_overflow set.
  - Accepted push with queue full and rd_en: both happen.
- RX read: rd_en with rx_valid advances the head. rd_en when empty is ignored (no flag).
- Sticky flags clear only on reset.
- Ordering: each queue is strictly FIFO; no reordering or duplication.

Test Plan:
- Reset then write 0x00AA0001, 0x00AA0002, 0x00AA0003 on consecutive cycles; pop once per cycle from cycle 2 -> D_pop shows 0x00AA0001, 0x00AA0002, 0x00AA0003 in order, pndng deasserts the cycle after the third pop, tx_count returns to 0.
- Default params (profundidad=8): 9 writes without pop -> tx_full=1 after 8, 9th dropped, tx_overflow=1. Then 8 pops return the first 8 packets in order; a pop on the empty queue sets pop_underflow=1.
- ID=3: push 0x03001234, 0xFF005678, 0x05009999 -> rx_count=2, rx_data sequence 0x03001234 then 0xFF005678, rx_drop_cnt=1.
- Fill RX to 8, then same-cycle accepted push + rd_en -> rx_count stays 8, no rx_overflow. Next cycle push without rd_en -> rx_overflow=1, rx_count=8.
- Fill TX with 5 packets, assert reset for one cycle mid-stream with pop high -> next cycle pndng=0, tx_count=0, flags 0. A subsequent write reappears on D_pop after 1 cycle.
- TX queue full, wr_en + pop in same cycle, repeated for 2*profundidad cycles -> count stays 8, no overflow, pointer wrap verified by exact packet order on D_pop.

Source files
------------

// File: rtl/fifo_terminal.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_terminal
//  Brief    : Device-side endpoint of the shared FIFO bus. A show-ahead TX
//             queue is drained by the bus (pndng/D_pop/pop), and an
//             ID-filtered RX queue is filled by bus pushes and read by the
//             agent.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_terminal #(
    parameter int         tama_de_paquete = 32,
    parameter int         profundidad     = 8,
    parameter logic [7:0] ID              = 8'h00,
    parameter logic [7:0] BROADCAST       = 8'hFF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [tama_de_paquete-1:0]         wr_data,
    output logic                               pndng,
    output logic [tama_de_paquete-1:0]         D_pop,
    input  logic                               pop,
    input  logic                               push,
    input  logic [tama_de_paquete-1:0]         D_push,
    output logic                               rx_valid,
    output logic [tama_de_paquete-1:0]         rx_data,
    input  logic                               rd_en,
    output logic [$clog2(profundidad+1)-1:0]   tx_count,
    output logic [$clog2(profundidad+1)-1:0]   rx_count,
    output logic                               tx_full,
    output logic                               tx_overflow,
    output logic                               pop_underflow,
    output logic                               rx_overflow,
    output logic [15:0]                        rx_drop_cnt
);

    localparam int PW = $clog2(profundidad);
    localparam int CW = $clog2(profundidad + 1);
    localparam logic [CW-1:0] c_DEPTH = CW'(profundidad);

    // ---------------------------------------------------------------- state
    logic [tama_de_paquete-1:0] r_tx_mem [profundidad];
    logic [tama_de_paquete-1:0] r_rx_mem [profundidad];
    logic [PW-1:0]              r_tx_rd, r_tx_wr, r_rx_rd, r_rx_wr;
    logic [CW-1:0]              r_tx_cnt, r_rx_cnt;
    logic                       r_tx_ovf, r_pop_uf, r_rx_ovf;
    logic [15:0]                r_drop;

    // ------------------------------------------------------------ decisions
    logic w_tx_empty, w_tx_full, w_tx_pop_ok, w_tx_wr_ok;
    logic w_rx_empty, w_rx_full, w_rx_acc, w_rx_rd_ok, w_rx_wr_ok;
    logic [7:0] w_rx_dest;

    assign w_tx_empty  = (r_tx_cnt == '0);
    assign w_tx_full   = (r_tx_cnt == c_DEPTH);
    // A pop on an empty queue never frees a slot, even if a write arrives
    // in the same cycle (the new packet is not yet visible to the bus).
    assign w_tx_pop_ok = pop && !w_tx_empty;
    assign w_tx_wr_ok  = wr_en && (!w_tx_full || w_tx_pop_ok);

    assign w_rx_dest   = D_push[tama_de_paquete-1 -: 8];
    assign w_rx_empty  = (r_rx_cnt == '0);
    assign w_rx_full   = (r_rx_cnt == c_DEPTH);
    assign w_rx_acc    = push && ((w_rx_dest == ID) || (w_rx_dest == BROADCAST));
    assign w_rx_rd_ok  = rd_en && !w_rx_empty;
    assign w_rx_wr_ok  = w_rx_acc && (!w_rx_full || w_rx_rd_ok);

    // TX storage: tail write; when full with a pop, tail == head and the
    // consumed slot is reused in the same cycle.
    always_ff @(posedge clk) begin
        if (w_tx_wr_ok) r_tx_mem[r_tx_wr] <= wr_data;
    end

    // RX storage: tail write of accepted packets
    always_ff @(posedge clk) begin
        if (w_rx_wr_ok) r_rx_mem[r_rx_wr] <= D_push;
    end

    // TX pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_rd  <= '0;
            r_tx_wr  <= '0;
            r_tx_cnt <= '0;
            r_tx_ovf <= 1'b0;
            r_pop_uf <= 1'b0;
        end else begin
            if (w_tx_wr_ok)  r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop_ok) r_tx_rd <= r_tx_rd + 1'b1;
            case ({w_tx_wr_ok, w_tx_pop_ok})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
            if (wr_en && w_tx_full && !w_tx_pop_ok) r_tx_ovf <= 1'b1;
            if (pop && w_tx_empty)                  r_pop_uf <= 1'b1;
        end
    end

    // RX pointers, occupancy, overflow flag and filter drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_rd  <= '0;
            r_rx_wr  <= '0;
            r_rx_cnt <= '0;
            r_rx_ovf <= 1'b0;
            r_drop   <= '0;
        end else begin
            if (w_rx_wr_ok) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_rd_ok) r_rx_rd <= r_rx_rd + 1'b1;
            case ({w_rx_wr_ok, w_rx_rd_ok})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
            if (w_rx_acc && w_rx_full && !w_rx_rd_ok) r_rx_ovf <= 1'b1;
            if (push && !w_rx_acc && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
        end
    end

    // ------------------------------------------------------------- outputs
    assign pndng         = !w_tx_empty;
    assign D_pop         = w_tx_empty ? '0 : r_tx_mem[r_tx_rd];
    assign rx_valid      = !w_rx_empty;
    assign rx_data       = w_rx_empty ? '0 : r_rx_mem[r_rx_rd];
    assign tx_count      = r_tx_cnt;
    assign rx_count      = r_rx_cnt;
    assign tx_full       = w_tx_full;
    assign tx_overflow   = r_tx_ovf;
    assign pop_underflow = r_pop_uf;
    assign rx_overflow   = r_rx_ovf;
    assign rx_drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fifo_terminal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_terminal
//  Brief    : Self-checking bench for fifo_terminal against a queue-based
//             reference model; directed scenarios followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_terminal;

    localparam int         c_PW    = 32;
    localparam int         c_DEPTH = 8;
    localparam logic [7:0] c_ID    = 8'h03;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0, pop = 1'b0, push = 1'b0, rd_en = 1'b0;
    logic [c_PW-1:0]   wr_data = '0, D_push = '0;
    logic              pndng, rx_valid, tx_full, tx_overflow, pop_underflow, rx_overflow;
    logic [c_PW-1:0]   D_pop, rx_data;
    logic [3:0]        tx_count, rx_count;
    logic [15:0]       rx_drop_cnt;

    fifo_terminal #(
        .tama_de_paquete (c_PW),
        .profundidad     (c_DEPTH),
        .ID              (c_ID),
        .BROADCAST       (8'hFF)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .pndng         (pndng),
        .D_pop         (D_pop),
        .pop           (pop),
        .push          (push),
        .D_push        (D_push),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rd_en         (rd_en),
        .tx_count      (tx_count),
        .rx_count      (rx_count),
        .tx_full       (tx_full),
        .tx_overflow   (tx_overflow),
        .pop_underflow (pop_underflow),
        .rx_overflow   (rx_overflow),
        .rx_drop_cnt   (rx_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [c_PW-1:0] m_tx[$];
    logic [c_PW-1:0] m_rx[$];
    logic            m_tx_ovf, m_pop_uf, m_rx_ovf;
    int              m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same rules, compare all outputs.
    task automatic step(input logic r, input logic w, input logic [c_PW-1:0] wd,
                        input logic p, input logic ps, input logic [c_PW-1:0] pd,
                        input logic rd);
        bit full, p_ok, w_ok, acc, r_ok;
        reset = r; wr_en = w; wr_data = wd; pop = p; push = ps; D_push = pd; rd_en = rd;
        @(posedge clk);
        if (r) begin
            m_tx.delete(); m_rx.delete();
            m_tx_ovf = 0; m_pop_uf = 0; m_rx_ovf = 0; m_drop = 0;
        end else begin
            full = (m_tx.size() == c_DEPTH);
            p_ok = p && (m_tx.size() != 0);
            w_ok = w && (!full || p_ok);
            if (p && m_tx.size() == 0) m_pop_uf = 1;
            if (w && full && !p_ok)    m_tx_ovf = 1;
            if (p_ok) void'(m_tx.pop_front());
            if (w_ok) m_tx.push_back(wd);

            acc  = ps && (pd[31:24] == c_ID || pd[31:24] == 8'hFF);
            r_ok = rd && (m_rx.size() != 0);
            if (ps && !acc && m_drop < 16'hFFFF) m_drop++;
            if (acc && m_rx.size() == c_DEPTH && !r_ok) m_rx_ovf = 1;
            if (r_ok) void'(m_rx.pop_front());
            if (acc && m_rx.size() < c_DEPTH) m_rx.push_back(pd);
        end
        #1;
        reset = 0; wr_en = 0; pop = 0; push = 0; rd_en = 0;
        chk("pndng",     32'(pndng),     32'(m_tx.size() != 0));
        chk("D_pop",     D_pop,          m_tx.size() != 0 ? m_tx[0] : 32'h0);
        chk("tx_count",  32'(tx_count),  32'(m_tx.size()));
        chk("tx_full",   32'(tx_full),   32'(m_tx.size() == c_DEPTH));
        chk("tx_ovf",    32'(tx_overflow), 32'(m_tx_ovf));
        chk("pop_uf",    32'(pop_underflow), 32'(m_pop_uf));
        chk("rx_valid",  32'(rx_valid),  32'(m_rx.size() != 0));
        chk("rx_data",   rx_data,        m_rx.size() != 0 ? m_rx[0] : 32'h0);
        chk("rx_count",  32'(rx_count),  32'(m_rx.size()));
        chk("rx_ovf",    32'(rx_overflow), 32'(m_rx_ovf));
        chk("drop_cnt",  32'(rx_drop_cnt), 32'(m_drop));
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, 0, '0, 0);
    endtask

    initial begin
        logic [c_PW-1:0] pd;
        m_tx_ovf = 0; m_pop_uf = 0; m_rx_ovf = 0; m_drop = 0;
        #2;

        // reset state: every output zero
        do_reset();
        chk("rst_all", {pndng, rx_valid, tx_full, tx_overflow, pop_underflow, rx_overflow,
                        D_pop[0], rx_data[0], tx_count, rx_count, rx_drop_cnt[0]}, 32'h0);

        // three writes, pops from cycle 2
        step(0, 1, 32'h00AA0001, 0, 0, '0, 0);
        chk("seq_head1", D_pop, 32'h00AA0001);
        step(0, 1, 32'h00AA0002, 1, 0, '0, 0);
        chk("seq_head2", D_pop, 32'h00AA0002);
        step(0, 1, 32'h00AA0003, 1, 0, '0, 0);
        chk("seq_head3", D_pop, 32'h00AA0003);
        step(0, 0, '0, 1, 0, '0, 0);
        chk("seq_pndng_off", 32'(pndng), 32'h0);
        chk("seq_cnt0", 32'(tx_count), 32'h0);

        // 9 writes without pop, then drain and pop once more
        for (int i = 0; i < 9; i++) step(0, 1, 32'h00B00000 + i, 0, 0, '0, 0);
        chk("ovf_full", 32'(tx_full), 32'h1);
        chk("ovf_flag", 32'(tx_overflow), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_head", D_pop, 32'h00B00000 + i);
            step(0, 0, '0, 1, 0, '0, 0);
        end
        step(0, 0, '0, 1, 0, '0, 0);
        chk("uf_flag", 32'(pop_underflow), 32'h1);

        // RX filter with ID=3
        do_reset();
        step(0, 0, '0, 0, 1, 32'h03001234, 0);
        step(0, 0, '0, 0, 1, 32'hFF005678, 0);
        step(0, 0, '0, 0, 1, 32'h05009999, 0);
        chk("flt_cnt", 32'(rx_count), 32'h2);
        chk("flt_drop", 32'(rx_drop_cnt), 32'h1);
        chk("flt_head1", rx_data, 32'h03001234);
        step(0, 0, '0, 0, 0, '0, 1);
        chk("flt_head2", rx_data, 32'hFF005678);
        step(0, 0, '0, 0, 0, '0, 1);
        step(0, 0, '0, 0, 0, '0, 1);  // read on empty: ignored

        // RX full: push+rd keeps count, then push alone overflows
        for (int i = 0; i < 8; i++) step(0, 0, '0, 0, 1, 32'h03C00000 + i, 0);
        step(0, 0, '0, 0, 1, 32'h03C00008, 1);
        chk("rx_keep8", 32'(rx_count), 32'h8);
        chk("rx_noovf", 32'(rx_overflow), 32'h0);
        step(0, 0, '0, 0, 1, 32'h03C00009, 0);
        chk("rx_ovf", 32'(rx_overflow), 32'h1);
        chk("rx_cnt8", 32'(rx_count), 32'h8);

        // mid-stream reset with pop high
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 32'h00D00000 + i, 0, 0, '0, 0);
        step(1, 0, '0, 1, 0, '0, 0);
        chk("mrst_pndng", 32'(pndng), 32'h0);
        chk("mrst_cnt", 32'(tx_count), 32'h0);
        chk("mrst_uf", 32'(pop_underflow), 32'h0);
        step(0, 1, 32'h00D0BEEF, 0, 0, '0, 0);
        chk("mrst_reappear", D_pop, 32'h00D0BEEF);

        // full TX, simultaneous write+pop for 2*depth cycles (wrap)
        for (int i = 0; i < 7; i++) step(0, 1, 32'h00E00001 + i, 0, 0, '0, 0);
        for (int i = 0; i < 2 * c_DEPTH; i++) step(0, 1, 32'h00F00000 + i, 1, 0, '0, 0);
        chk("wrap_cnt", 32'(tx_count), 32'h8);
        chk("wrap_noovf", 32'(tx_overflow), 32'h0);
        chk("wrap_head", D_pop, 32'h00F00008);

        // random traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 2))
                0:       pd = {c_ID, 24'($urandom)};
                1:       pd = {8'hFF, 24'($urandom)};
                default: pd = $urandom;
            endcase
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 55, $urandom,
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 55, pd,
                 $urandom_range(0, 99) < 45);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
